// File: rtl/alu_share_if.sv
// ---------------------------------------------------------------------------
// alu_share_if
// Request/response bundle between the issuing units and alu_share_arbiter.
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_op     : 3-bit op codes, requester i at [3*i+:3]
//   req_a/b    : operands, requester i at [WIDTH*i+:WIDTH]
//   rsp_valid  : response valid
//   rsp_ready  : response consumer ready
//   rsp_id     : index of the requester owning the response
//   rsp_result : captured ALU result
//   rsp_err    : op code was unsupported
// master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_share_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [3*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU between NUM_REQ requesters using
// round-robin arbitration. One transaction is in flight at a time:
// IDLE (grant) -> EXEC (registered operands drive the ALU) -> RESP (result
// held until the consumer takes it).
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : request/response bundle (alu_share_if.slave)
//   alu_a/b    : registered operands to the ALU
//   alu_ctrl   : registered op code to the ALU
//   alu_result : combinational result from the ALU
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_if.slave       bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_result;
    logic              r_err;

    logic              w_found;
    logic [ID_W-1:0]   w_gnt;
    logic              w_accept;
    logic              w_capture;
    int                w_idx;

    // Op codes the ALU does not implement; it returns 0 for them.
    function automatic logic f_op_err(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
    endfunction

    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // rst_n gating keeps req_ready low while reset is held,
                // since req_ready is combinational from req_valid here.
                if (w_found && rst_n) begin
                    bus.req_ready = NUM_REQ'(1) << w_gnt;
                    w_accept      = 1'b1;
                    w_state_nxt   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_op     <= 3'b000;
            r_a      <= '0;
            r_b      <= '0;
            r_rsp_id <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id  <= w_gnt;
                r_op  <= bus.req_op[3*int'(w_gnt) +: 3];
                r_a   <= bus.req_a[WIDTH*int'(w_gnt) +: WIDTH];
                r_b   <= bus.req_b[WIDTH*int'(w_gnt) +: WIDTH];
                r_ptr <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
            end
            if (w_capture) begin
                r_result <= alu_result;
                r_err    <= f_op_err(r_op);
                r_rsp_id <= r_id;
            end
        end
    end

    // ALU inputs come only from the latched registers, never from req_*.
    assign alu_a          = r_a;
    assign alu_b          = r_b;
    assign alu_ctrl       = r_op;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_err    = r_err;

endmodule
